tdc_meas_ctrl: RTL and testbench

TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

---
 rtl/tdc_meas_ctrl.sv | 99 +++++++++
 tb/tb_tdc_meas_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: sequences one start/stop TDC measurement and buffers its merged result
//    clk, rst          rising-edge clock, synchronous active-high reset
//    arm               host level; measurements are requested while high
//    start_hit         start edge pulse
//    stop_hit          stop edge pulse
//    merge_done        merging stage done pulse, qualifies merge_data
//    merge_data        merged {coarse, start fine, stop fine} word
//    store_start       strobe latching the start fine code
//    store_stop        strobe latching the stop fine code and coarse count
//    tdc_rst           clear pulse to delay line, decoders and coarse counter
//    busy              controller is not idle
//    res_valid         result buffer full
//    res_ready         consumer accepts the result on res_valid & res_ready
//    res_data          buffered result
//    res_status        00 ok, 01 stop timeout, 10 merge timeout
module tdc_meas_ctrl #(
   parameter int DW       = 32,
   parameter int TIMEOUT  = 1000,
   parameter int MERGE_TO = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          start_hit,
   input  logic          stop_hit,
   input  logic          merge_done,
   input  logic [DW-1:0] merge_data,
   output logic          store_start,
   output logic          store_stop,
   output logic          tdc_rst,
   output logic          busy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [1:0]    res_status
);
   localparam int TMAX = TIMEOUT > MERGE_TO ? TIMEOUT : MERGE_TO;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CLEAR     = 3'd1;
   localparam logic [2:0] ARMED     = 3'd2;
   localparam logic [2:0] WAIT_STOP = 3'd3;
   localparam logic [2:0] MERGE     = 3'd4;
   logic [2:0]    state, state_nx;
   logic [TW-1:0] timer;
   logic          free, stop_to, merge_to, merge_ok, load, start_ok;
   logic [DW-1:0] load_data;
   logic [1:0]    load_status;
   always_comb begin
      free        = !res_valid || res_ready;
      start_ok    = state == ARMED && arm && start_hit;
      merge_ok    = state == MERGE && merge_done;
      stop_to     = state == WAIT_STOP && !stop_hit && timer == TW'(TIMEOUT - 1);
      merge_to    = state == MERGE && !merge_done && timer == TW'(MERGE_TO - 1);
      load        = merge_ok || stop_to || merge_to;
      load_data   = merge_ok ? merge_data : '0;
      load_status = stop_to ? 2'b01 : merge_to ? 2'b10 : 2'b00;
      state_nx    = state;
      case (state)
         IDLE:      state_nx = arm && free ? CLEAR : IDLE;
         // A result just loaded keeps the buffer full here, so re-arming waits
         // in IDLE for the handshake instead of starting a measurement that
         // could overwrite it.
         CLEAR:     state_nx = arm && free ? ARMED : IDLE;
         ARMED:     state_nx = !arm ? CLEAR : start_hit ? (stop_hit ? MERGE : WAIT_STOP) : ARMED;
         WAIT_STOP: state_nx = stop_hit ? MERGE : stop_to ? CLEAR : WAIT_STOP;
         MERGE:     state_nx = merge_done || merge_to ? CLEAR : MERGE;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         store_start <= 1'b0;
         store_stop  <= 1'b0;
         tdc_rst     <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_status  <= 2'b00;
      end else begin
         state       <= state_nx;
         // Timeouts force an exit before the timer can exceed its range.
         timer       <= (state_nx == state && (state == WAIT_STOP || state == MERGE)) ? timer + 1'b1 : '0;
         store_start <= start_ok;
         store_stop  <= (start_ok && stop_hit) || (state == WAIT_STOP && stop_hit);
         tdc_rst     <= state_nx == CLEAR;
         busy        <= state_nx != IDLE;
         if (load) begin
            res_valid  <= 1'b1;
            res_data   <= load_data;
            res_status <= load_status;
         end else if (res_ready) begin
            res_valid  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: directed self-checking bench for tdc_meas_ctrl
module tb_tdc_meas_ctrl;
   logic        clk = 1'b0;
   logic        rst, arm, start_hit, stop_hit, merge_done, res_ready;
   logic [31:0] merge_data;
   logic        store_start, store_stop, tdc_rst, busy, res_valid;
   logic [31:0] res_data;
   logic [1:0]  res_status;
   int          n_chk = 0;
   int          n_fail = 0;
   tdc_meas_ctrl #(.DW(32), .TIMEOUT(64), .MERGE_TO(6)) dut (
      .clk(clk), .rst(rst), .arm(arm), .start_hit(start_hit), .stop_hit(stop_hit),
      .merge_done(merge_done), .merge_data(merge_data), .store_start(store_start),
      .store_stop(store_stop), .tdc_rst(tdc_rst), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_status(res_status)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] outs();
      return {25'd0, busy, tdc_rst, store_start, store_stop, res_valid, res_status, res_data};
   endfunction
   initial begin
      rst = 1'b1; arm = 1'b0; start_hit = 1'b0; stop_hit = 1'b0;
      merge_done = 1'b0; merge_data = '0; res_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      check("reset_outs", outs(), 64'd0);
      // nominal measurement, cycle numbers relative to arm rising
      arm = 1'b1;
      step();
      check("c1_tdc_rst", tdc_rst, 1'b1);
      check("c1_busy", busy, 1'b1);
      step();
      check("c2_tdc_rst", tdc_rst, 1'b0);
      stop_hit = 1'b1; step(); stop_hit = 1'b0;
      check("lone_stop_ignored", store_stop, 1'b0);
      step(); step();
      start_hit = 1'b1; step(); start_hit = 1'b0;
      check("c6_store_start", store_start, 1'b1);
      check("c6_store_stop", store_stop, 1'b0);
      step();
      check("c7_store_start", store_start, 1'b0);
      repeat (33) step();
      stop_hit = 1'b1; step(); stop_hit = 1'b0;
      check("c41_store_stop", store_stop, 1'b1);
      check("c41_store_start", store_start, 1'b0);
      repeat (4) step();
      merge_data = 32'h00A3_1207; merge_done = 1'b1; step(); merge_done = 1'b0;
      check("c46_res_valid", res_valid, 1'b1);
      check("c46_res_data", res_data, 32'h00A3_1207);
      check("c46_res_status", res_status, 2'b00);
      check("c46_tdc_rst", tdc_rst, 1'b1);
      // buffer full, arm held: controller idles until the handshake
      step();
      check("hold_busy", busy, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_tdc_rst", tdc_rst, 1'b0);
         check("hold_busy", busy, 1'b0);
         check("hold_res_valid", res_valid, 1'b1);
         check("hold_res_data", res_data, 32'h00A3_1207);
      end
      res_ready = 1'b1; step();
      check("hs_res_valid", res_valid, 1'b0);
      check("rearm_tdc_rst", tdc_rst, 1'b1);
      step();
      check("rearm_busy", busy, 1'b1);
      check("rearm_tdc_rst_off", tdc_rst, 1'b0);
      // start and stop together, then merge timeout
      start_hit = 1'b1; stop_hit = 1'b1; step(); start_hit = 1'b0; stop_hit = 1'b0;
      check("both_store_start", store_start, 1'b1);
      check("both_store_stop", store_stop, 1'b1);
      repeat (5) step();
      check("mto_pre_valid", res_valid, 1'b0);
      check("mto_pre_busy", busy, 1'b1);
      step();
      check("mto_valid", res_valid, 1'b1);
      check("mto_status", res_status, 2'b10);
      check("mto_data", res_data, 32'd0);
      check("mto_tdc_rst", tdc_rst, 1'b1);
      step();
      check("mto_drained", res_valid, 1'b0);
      check("mto_rearmed", busy, 1'b1);
      // merge_done on the merge timeout cycle wins
      start_hit = 1'b1; stop_hit = 1'b1; step(); start_hit = 1'b0; stop_hit = 1'b0;
      repeat (5) step();
      merge_data = 32'h1234_5678; merge_done = 1'b1; step(); merge_done = 1'b0;
      check("mprio_valid", res_valid, 1'b1);
      check("mprio_status", res_status, 2'b00);
      check("mprio_data", res_data, 32'h1234_5678);
      step();
      // stop timeout after 64 WAIT_STOP cycles
      start_hit = 1'b1; step(); start_hit = 1'b0;
      check("sto_store_start", store_start, 1'b1);
      check("sto_store_stop", store_stop, 1'b0);
      repeat (63) step();
      check("sto_pre_valid", res_valid, 1'b0);
      check("sto_pre_busy", busy, 1'b1);
      step();
      check("sto_valid", res_valid, 1'b1);
      check("sto_status", res_status, 2'b01);
      check("sto_data", res_data, 32'd0);
      check("sto_tdc_rst", tdc_rst, 1'b1);
      check("sto_no_stop", store_stop, 1'b0);
      step();
      // stop_hit on the timeout cycle wins
      start_hit = 1'b1; step(); start_hit = 1'b0;
      repeat (63) step();
      stop_hit = 1'b1; step(); stop_hit = 1'b0;
      check("sprio_store_stop", store_stop, 1'b1);
      check("sprio_no_result", res_valid, 1'b0);
      merge_data = 32'hCAFE_0001; merge_done = 1'b1; step(); merge_done = 1'b0;
      check("sprio_valid", res_valid, 1'b1);
      check("sprio_status", res_status, 2'b00);
      check("sprio_data", res_data, 32'hCAFE_0001);
      step();
      // arm dropped in WAIT_STOP: measurement completes
      start_hit = 1'b1; step(); start_hit = 1'b0;
      arm = 1'b0;
      repeat (3) step();
      check("wdrop_busy", busy, 1'b1);
      stop_hit = 1'b1; step(); stop_hit = 1'b0;
      check("wdrop_store_stop", store_stop, 1'b1);
      merge_data = 32'h0BAD_F00D; merge_done = 1'b1; step(); merge_done = 1'b0;
      check("wdrop_valid", res_valid, 1'b1);
      check("wdrop_data", res_data, 32'h0BAD_F00D);
      step();
      check("wdrop_idle", busy, 1'b0);
      check("wdrop_tdc_rst", tdc_rst, 1'b0);
      // arm dropped in ARMED: one clear pulse, no result
      arm = 1'b1; step();
      check("adrop_clear", tdc_rst, 1'b1);
      step();
      arm = 1'b0; step();
      check("adrop_tdc_rst", tdc_rst, 1'b1);
      check("adrop_no_result", res_valid, 1'b0);
      step();
      check("adrop_idle", busy, 1'b0);
      check("adrop_tdc_rst_off", tdc_rst, 1'b0);
      check("adrop_still_empty", res_valid, 1'b0);
      // reset in WAIT_STOP
      arm = 1'b1; step(); step();
      start_hit = 1'b1; step(); start_hit = 1'b0;
      step();
      rst = 1'b1; step(); rst = 1'b0; arm = 1'b0;
      check("rst_wait_outs", outs(), 64'd0);
      step();
      check("rst_wait_no_tdc_rst", tdc_rst, 1'b0);
      // reset with a full buffer
      res_ready = 1'b0; arm = 1'b1; step(); step();
      start_hit = 1'b1; stop_hit = 1'b1; step(); start_hit = 1'b0; stop_hit = 1'b0;
      merge_data = 32'h0000_0055; merge_done = 1'b1; step(); merge_done = 1'b0;
      check("rst_full_pre", res_valid, 1'b1);
      rst = 1'b1; step(); rst = 1'b0; arm = 1'b0;
      check("rst_full_outs", outs(), 64'd0);
      // reset in MERGE, later merge_done ignored
      res_ready = 1'b1; arm = 1'b1; step(); step();
      start_hit = 1'b1; stop_hit = 1'b1; step(); start_hit = 1'b0; stop_hit = 1'b0;
      rst = 1'b1; step(); rst = 1'b0; arm = 1'b0;
      check("rst_merge_outs", outs(), 64'd0);
      merge_data = 32'h0000_0077; merge_done = 1'b1; step(); merge_done = 1'b0;
      check("late_merge_valid", res_valid, 1'b0);
      check("late_merge_data", res_data, 32'd0);
      check("late_merge_busy", busy, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
